// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: checks VGA frame timing on pix_clk. It counts the pixels in
// each line and the lines in each frame, pulses an error when a line or a frame
// has the wrong size, counts completed frames and reports lock.
// Optional feature: define VGA_MON_CHECKSUM_EN to add the frame_sum output, the
// sum of vga_red over the last completed frame.
module vga_frame_monitor #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480
) (
   input  logic        pix_clk,
   input  logic        reset,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [7:0]  vga_red,
   input  logic        data_valid,
   output logic [9:0]  pix_x,
   output logic [8:0]  pix_y,
   output logic        frame_done,
   output logic        line_len_err,
   output logic        frame_len_err,
   output logic [15:0] frame_count,
   output logic        locked
`ifdef VGA_MON_CHECKSUM_EN
   ,
   output logic [26:0] frame_sum
`endif
);

   localparam logic [9:0] H_ACT_W = 10'(H_ACTIVE);
   localparam logic [8:0] V_ACT_W = 9'(V_ACTIVE);

   typedef enum logic [1:0] {IDLE, VSYNC, FRAME} state_t;

   state_t      state_p0, state_nxt;
   logic        vsync_p0, hsync_p0, vld_p0;
   logic [9:0]  pix_cnt_p0;
   logic [8:0]  line_cnt_p0;
   logic        frame_err_p0;

   logic        vs_fall, vs_rise, hs_fall, in_frame, accept, line_open;
   logic        dv_close, hs_close, line_close, line_bad, frame_end, frame_bad;
   logic [8:0]  lines_eff;

   function automatic logic [9:0] sat_pix(input logic [9:0] c);
      return (c == 10'd1023) ? c : c + 10'd1;
   endfunction

   function automatic logic [8:0] sat_line(input logic [8:0] c);
      return (c == 9'd511) ? c : c + 9'd1;
   endfunction

   // Edge detection and line/frame close decisions for the current cycle.
   always_comb begin
      vs_fall    = vsync_p0 & ~vsync;
      vs_rise    = ~vsync_p0 & vsync;
      hs_fall    = hsync_p0 & ~hsync;
      in_frame   = (state_p0 == FRAME);
      accept     = in_frame & data_valid;
      line_open  = (pix_cnt_p0 != 10'd0);
      dv_close   = in_frame & vld_p0 & ~data_valid & line_open;
      hs_close   = accept & hs_fall & line_open;
      line_close = dv_close | hs_close;
      line_bad   = line_close & (pix_cnt_p0 != H_ACT_W);
      frame_end  = in_frame & vs_fall;
      // A line closing in the frame-end cycle is counted before the frame check.
      lines_eff  = line_close ? sat_line(line_cnt_p0) : line_cnt_p0;
      frame_bad  = frame_end & (lines_eff != V_ACT_W);
   end

   // Next-state logic: frames are bounded by vsync falling edges.
   always_comb begin
      state_nxt = state_p0;
      case (state_p0)
         IDLE:    if (vs_fall) state_nxt = VSYNC;
         VSYNC:   if (vs_rise) state_nxt = FRAME;
         FRAME:   if (vs_fall) state_nxt = VSYNC;
         default: state_nxt = IDLE;
      endcase
   end

   // State register and previous-cycle copies of the sync and valid inputs.
   always_ff @(posedge pix_clk) begin
      if (reset) begin
         state_p0 <= IDLE;
         vsync_p0 <= 1'b1;
         hsync_p0 <= 1'b1;
         vld_p0   <= 1'b0;
      end else begin
         state_p0 <= state_nxt;
         vsync_p0 <= vsync;
         hsync_p0 <= hsync;
         vld_p0   <= data_valid;
      end
   end

   // Pixel, line and frame-error bookkeeping for the frame in progress.
   always_ff @(posedge pix_clk) begin
      if (reset) begin
         pix_cnt_p0   <= '0;
         line_cnt_p0  <= '0;
         frame_err_p0 <= 1'b0;
      end else if (frame_end) begin
         pix_cnt_p0   <= '0;
         line_cnt_p0  <= '0;
         frame_err_p0 <= 1'b0;
      end else begin
         if (hs_close)
            pix_cnt_p0 <= 10'd1;
         else if (dv_close)
            pix_cnt_p0 <= '0;
         else if (accept)
            pix_cnt_p0 <= sat_pix(pix_cnt_p0);
         if (line_close)
            line_cnt_p0 <= sat_line(line_cnt_p0);
         if (line_bad)
            frame_err_p0 <= 1'b1;
      end
   end

   // Registered outputs: position of the last pixel, pulses, frame count, lock.
   always_ff @(posedge pix_clk) begin
      if (reset) begin
         pix_x         <= '0;
         pix_y         <= '0;
         frame_done    <= 1'b0;
         line_len_err  <= 1'b0;
         frame_len_err <= 1'b0;
         frame_count   <= '0;
         locked        <= 1'b0;
      end else begin
         if (accept) begin
            if (hs_close) begin
               pix_x <= '0;
               pix_y <= sat_line(line_cnt_p0);
            end else begin
               pix_x <= pix_cnt_p0;
               pix_y <= line_cnt_p0;
            end
         end
         frame_done    <= frame_end;
         line_len_err  <= line_bad;
         frame_len_err <= frame_bad;
         if (frame_end)
            frame_count <= frame_count + 16'd1;
         if (line_bad | frame_bad)
            locked <= 1'b0;
         else if (frame_end & ~frame_err_p0)
            locked <= 1'b1;
      end
   end

`ifdef VGA_MON_CHECKSUM_EN
   logic [26:0] acc_p0;
   logic [26:0] acc_sum;

   // Running sum including the pixel accepted this cycle.
   always_comb begin
      acc_sum = acc_p0;
      if (accept)
         acc_sum = acc_p0 + {19'd0, vga_red};
   end

   // Checksum accumulator; snapshot into frame_sum at each frame end.
   always_ff @(posedge pix_clk) begin
      if (reset) begin
         acc_p0    <= '0;
         frame_sum <= '0;
      end else if (frame_end) begin
         acc_p0    <= '0;
         frame_sum <= acc_sum;
      end else begin
         acc_p0    <= acc_sum;
      end
   end
`else
   logic unused_red;
   assign unused_red = ^vga_red;
`endif

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor with a reduced 8x4 frame geometry.
module tb_vga_frame_monitor;

   localparam int H = 8;
   localparam int V = 4;

   logic        pix_clk = 1'b0;
   logic        reset = 1'b1;
   logic        hsync = 1'b1;
   logic        vsync = 1'b1;
   logic [7:0]  vga_red = 8'd0;
   logic        data_valid = 1'b0;
   logic [9:0]  pix_x;
   logic [8:0]  pix_y;
   logic        frame_done, line_len_err, frame_len_err, locked;
   logic [15:0] frame_count;
`ifdef VGA_MON_CHECKSUM_EN
   logic [26:0] frame_sum;
`endif

   vga_frame_monitor #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
      .pix_clk(pix_clk), .reset(reset), .hsync(hsync), .vsync(vsync),
      .vga_red(vga_red), .data_valid(data_valid), .pix_x(pix_x), .pix_y(pix_y),
      .frame_done(frame_done), .line_len_err(line_len_err),
      .frame_len_err(frame_len_err), .frame_count(frame_count), .locked(locked)
`ifdef VGA_MON_CHECKSUM_EN
      , .frame_sum(frame_sum)
`endif
   );

   always #5 pix_clk = ~pix_clk;

   int total = 0;
   int bad = 0;
   int n_le = 0;
   int n_fd = 0;

   always @(negedge pix_clk) begin
      if (line_len_err === 1'b1) n_le++;
      if (frame_done === 1'b1) n_fd++;
   end

   typedef struct {
      int         nlines;
      int         bad_line;
      int         bad_len;
      logic [7:0] red;
      int         exp_le;
      bit         exp_fle;
      bit         exp_lock;
      int         exp_cnt;
   } vec_t;

   vec_t vecs[8];

   task automatic tick();
      @(posedge pix_clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic blank(input int n);
      for (int i = 0; i < n; i++) begin
         hsync = (i == 1 || i == 2) ? 1'b0 : 1'b1;
         tick();
      end
      hsync = 1'b1;
   endtask

   task automatic send_line(input int npix, input logic [7:0] red,
                            output bit err, output bit lk);
      for (int i = 0; i < npix; i++) begin
         data_valid = 1'b1;
         vga_red = red;
         tick();
      end
      data_valid = 1'b0;
      tick();
      err = line_len_err;
      lk = locked;
      blank(5);
   endtask

   task automatic vs_tail();
      tick();
      tick();
      vsync = 1'b1;
      tick();
      tick();
      tick();
   endtask

   initial begin
      bit   e, lk;
      int   le0, len;
      logic [26:0] exp_sum;

      vecs[0] = '{4, -1, 0, 8'hFF, 0, 1'b0, 1'b1, 1};
      vecs[1] = '{4, -1, 0, 8'h01, 0, 1'b0, 1'b1, 2};
      vecs[2] = '{4,  1, 7, 8'h10, 1, 1'b0, 1'b0, 3};
      vecs[3] = '{4, -1, 0, 8'h02, 0, 1'b0, 1'b1, 4};
      vecs[4] = '{3, -1, 0, 8'h03, 0, 1'b1, 1'b0, 5};
      vecs[5] = '{5, -1, 0, 8'h04, 0, 1'b1, 1'b0, 6};
      vecs[6] = '{4,  2, 9, 8'h05, 1, 1'b0, 1'b0, 7};
      vecs[7] = '{4, -1, 0, 8'h06, 0, 1'b0, 1'b1, 8};

      // reset for three cycles
      tick(); tick(); tick();
      chk("rst_pix_x", 32'(pix_x), 0);
      chk("rst_pix_y", 32'(pix_y), 0);
      chk("rst_fdone", 32'(frame_done), 0);
      chk("rst_lerr", 32'(line_len_err), 0);
      chk("rst_ferr", 32'(frame_len_err), 0);
      chk("rst_fcount", 32'(frame_count), 0);
      chk("rst_locked", 32'(locked), 0);
`ifdef VGA_MON_CHECKSUM_EN
      chk("rst_fsum", 32'(frame_sum), 0);
`endif
      reset = 1'b0;

      // partial frame before the first vsync is never reported
      send_line(H, 8'h11, e, lk);
      send_line(3, 8'h11, e, lk);
      vsync = 1'b0;
      tick();
      chk("partial_fdone", 32'(frame_done), 0);
      chk("partial_lerr_cnt", 32'(n_le), 0);
      vs_tail();

      for (int v = 0; v < 8; v++) begin
         le0 = n_le;
         exp_sum = '0;
         for (int l = 0; l < vecs[v].nlines; l++) begin
            len = (l == vecs[v].bad_line) ? vecs[v].bad_len : H;
            send_line(len, vecs[v].red, e, lk);
            exp_sum += 27'(len) * 27'(vecs[v].red);
            if (l == vecs[v].bad_line) begin
               chk($sformatf("v%0d_lerr_pulse", v), 32'(e), 1);
               chk($sformatf("v%0d_lock_at_lerr", v), 32'(lk), 0);
            end
         end
         vsync = 1'b0;
         tick();
         chk($sformatf("v%0d_fdone", v), 32'(frame_done), 1);
         chk($sformatf("v%0d_ferr", v), 32'(frame_len_err), 32'(vecs[v].exp_fle));
         chk($sformatf("v%0d_locked", v), 32'(locked), 32'(vecs[v].exp_lock));
         chk($sformatf("v%0d_fcount", v), 32'(frame_count), 32'(vecs[v].exp_cnt));
         chk($sformatf("v%0d_lerr_cnt", v), 32'(n_le - le0), 32'(vecs[v].exp_le));
`ifdef VGA_MON_CHECKSUM_EN
         chk($sformatf("v%0d_fsum", v), 32'(frame_sum), 32'(exp_sum));
`endif
         tick();
         chk($sformatf("v%0d_fdone_end", v), 32'(frame_done), 0);
         tick();
         vsync = 1'b1;
         tick(); tick(); tick();
      end

      // data_valid held across an hsync falling edge splits two lines
      le0 = n_le;
      for (int i = 0; i < 2 * H; i++) begin
         data_valid = 1'b1;
         vga_red = 8'h01;
         hsync = (i == H || i == H + 1) ? 1'b0 : 1'b1;
         tick();
         if (i == H - 1) begin
            chk("hs_pix_x_before", 32'(pix_x), H - 1);
            chk("hs_pix_y_before", 32'(pix_y), 0);
         end
         if (i == H) begin
            chk("hs_pix_x_after", 32'(pix_x), 0);
            chk("hs_pix_y_after", 32'(pix_y), 1);
         end
      end
      hsync = 1'b1;
      data_valid = 1'b0;
      tick();
      blank(5);
      send_line(H, 8'h01, e, lk);
      send_line(H, 8'h01, e, lk);
      chk("hs_last_pix_x", 32'(pix_x), H - 1);
      chk("hs_last_pix_y", 32'(pix_y), V - 1);
      vsync = 1'b0;
      tick();
      chk("hs_fdone", 32'(frame_done), 1);
      chk("hs_ferr", 32'(frame_len_err), 0);
      chk("hs_lerr_cnt", 32'(n_le - le0), 0);
      chk("hs_locked", 32'(locked), 1);
      vs_tail();

      // last line closes in the same cycle as the vsync falling edge
      for (int l = 0; l < V - 1; l++) send_line(H, 8'h02, e, lk);
      for (int i = 0; i < H; i++) begin
         data_valid = 1'b1;
         tick();
      end
      data_valid = 1'b0;
      vsync = 1'b0;
      tick();
      chk("co_fdone", 32'(frame_done), 1);
      chk("co_ferr", 32'(frame_len_err), 0);
      chk("co_lerr", 32'(line_len_err), 0);
      chk("co_fcount", 32'(frame_count), 10);
      vs_tail();

      // reset in the middle of a frame discards it
      send_line(H, 8'h03, e, lk);
      send_line(H, 8'h03, e, lk);
      reset = 1'b1;
      tick();
      chk("mid_rst_pix_x", 32'(pix_x), 0);
      chk("mid_rst_pix_y", 32'(pix_y), 0);
      chk("mid_rst_fcount", 32'(frame_count), 0);
      chk("mid_rst_locked", 32'(locked), 0);
      chk("mid_rst_fdone", 32'(frame_done), 0);
      reset = 1'b0;
      le0 = n_le;
      send_line(H, 8'h03, e, lk);
      send_line(5, 8'h03, e, lk);
      vsync = 1'b0;
      tick();
      chk("mid_rst_no_fdone", 32'(frame_done), 0);
      chk("mid_rst_no_lerr", 32'(n_le - le0), 0);
      vs_tail();
      for (int l = 0; l < V; l++) send_line(H, 8'h07, e, lk);
      vsync = 1'b0;
      tick();
      chk("post_rst_fdone", 32'(frame_done), 1);
      chk("post_rst_fcount", 32'(frame_count), 1);
      chk("post_rst_locked", 32'(locked), 1);
      chk("post_rst_ferr", 32'(frame_len_err), 0);
`ifdef VGA_MON_CHECKSUM_EN
      chk("post_rst_fsum", 32'(frame_sum), H * V * 7);
`endif
      vs_tail();
      chk("total_fdone_pulses", 32'(n_fd), 11);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vga_frame_monitor.md
VGA_FRAME_MONITOR -- requirements
Module: vga_frame_monitor

Interface
REQ-001 Parameter H_ACTIVE, default 640, required valid pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, required active lines per frame.
REQ-003 pix_clk  input  1  pixel clock; all logic on its rising edge; one clock domain only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 hsync  input  1  horizontal sync, active-low.
REQ-006 vsync  input  1  vertical sync, active-low.
REQ-007 vga_red  input  8  pixel data from the upstream VGA timing stage.
REQ-008 data_valid  input  1  high for each active pixel.
REQ-009 pix_x  output  10  column of the last accepted pixel.
REQ-010 pix_y  output  9  row of the last accepted pixel.
REQ-011 frame_done  output  1  one-cycle pulse at the end of each frame.
REQ-012 line_len_err  output  1  one-cycle pulse when a line's length is wrong.
REQ-013 frame_len_err  output  1  one-cycle pulse when a frame's line count is wrong.
REQ-014 frame_count  output  16  number of completed frames; wraps.
REQ-015 locked  output  1  high while frames are error-free.
REQ-016 frame_sum  output  27  sum of vga_red over the last completed frame; present only with the macro (REQ-033).

Function
REQ-017 FSM states: IDLE, VSYNC, FRAME.
- IDLE -> VSYNC on the vsync falling edge.
- VSYNC -> FRAME on the vsync rising edge.
- FRAME -> VSYNC on the vsync falling edge.
- Edges are detected against the previous-cycle registered vsync.
REQ-018 In FRAME, each data_valid=1 cycle increments the pixel counter, saturating at 1023.
REQ-019 pix_x/pix_y update one cycle after each accepted pixel and hold otherwise.
REQ-020 A data_valid 1->0 transition in FRAME closes the line.
- If pixel count != H_ACTIVE: line_len_err pulses on the next cycle and sets an internal frame-error flag.
- Line counter increments, saturating at 511.
- Pixel counter clears.
REQ-021 data_valid in IDLE or VSYNC is ignored: no counting, no error.
REQ-022 hsync is only used to close a line still open when hsync falls.
- data_valid high across an hsync falling edge closes the line at that edge.
- The same pixel then starts the next line.
REQ-023 Frame end (FRAME -> VSYNC):
- If line count != V_ACTIVE, frame_len_err pulses on the next cycle.
- frame_done pulses on the next cycle.
- frame_count increments by 1; 16'hFFFF wraps to 0.
- Line counter and frame-error flag clear.
REQ-024 If data_valid falls in the same cycle as the vsync falling edge, the line closes first, so the line is counted before the frame check.
REQ-025 locked sets with frame_done on a frame with no line_len_err and no frame_len_err.
- It clears in the cycle any error pulses.
REQ-026 The partial frame between reset release and the first vsync falling edge is never reported.
REQ-027 Latency: each error pulse and frame_done is exactly one cycle after the causing edge.

Reset
REQ-028 Reset forces state IDLE and clears all counters, flags and accumulators.
REQ-029 Reset output values: pix_x=0, pix_y=0, frame_done=0, line_len_err=0, frame_len_err=0, frame_count=0, locked=0, frame_sum=0.
REQ-030 Reset asserted mid-frame discards the frame: no frame_done and no error pulse.
REQ-031 Reset has priority over every other event in the same cycle.

Configuration
REQ-032 Macro VGA_MON_CHECKSUM_EN enables the checksum.
REQ-033 With VGA_MON_CHECKSUM_EN defined:
- A 27-bit accumulator adds vga_red on each accepted pixel.
- frame_sum is loaded in the frame_done cycle and holds until the next frame_done.
- The accumulator clears at frame end.
REQ-034 Without the macro: frame_sum port and accumulator are absent; all other behaviour is identical.

Verification
REQ-035 Reset 3 cycles, then 2 frames of 480 lines x 640 valid pixels (160-cycle hsync blank, vsync pulses) -> one frame_done per frame, frame_count=2, locked=1, no error pulses.
REQ-036 One line of 639 pixels mid-frame -> single line_len_err one cycle after valid falls; locked=0 at that cycle; next clean frame -> locked=1.
REQ-037 Frame of 479 lines -> frame_len_err and frame_done together, one cycle after the vsync falling edge; frame_count still increments.
REQ-038 Checksum build, all pixels vga_red=8'hFF -> frame_sum=78,336,000; all 8'h01 -> frame_sum=307,200.
REQ-039 Reset pulsed at line 200 -> all outputs 0 next cycle; no frame_done until a full frame after the next vsync edge.
REQ-040 data_valid fall coincident with the vsync falling edge on line 480 -> no frame_len_err; frame_done pulses.
